// File: rtl/lcd_text_writer_if.sv
// Handshake between the text writer and the character-LCD driver:
// one START pulse per character, acknowledged by the driver's BUSY.
interface lcd_text_writer_if;
  logic       lcd_start;
  logic       lcd_busy;
  logic [7:0] lcd_addr;
  logic [7:0] lcd_char;

  modport master (output lcd_start, output lcd_addr, output lcd_char, input lcd_busy);
  modport slave  (input lcd_start, input lcd_addr, input lcd_char, output lcd_busy);
endinterface

// File: rtl/lcd_text_writer.sv
// 2x16 character frame buffer that streams changed cells to the LCD driver,
// one START/BUSY transaction per dirty cell, scanning cells round-robin.
module lcd_text_writer #(
  parameter logic [7:0] BLANK_CHAR  = 8'h20,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [4:0]               i_wr_addr,
  input  logic [7:0]               i_wr_data,
  input  logic                     i_refresh,
  lcd_text_writer_if.master        lcd,
  output logic                     o_idle
);

  localparam int              TW         = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    SCAN,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t        r_state;
  logic [7:0]    r_cells [32];
  logic [31:0]   r_dirty;
  logic [4:0]    r_ptr;
  logic [TW-1:0] r_timer;
  logic          r_start;
  logic [7:0]    r_addr;
  logic [7:0]    r_char;
  logic          w_busy;

  // Cells 0-15 map to DDRAM 0x00-0x0F, cells 16-31 to 0x40-0x4F.
  function automatic logic [7:0] ddram_addr(input logic [4:0] idx);
    return {1'b0, idx[4], 2'b00, idx[3:0]};
  endfunction

  assign w_busy = lcd.lcd_busy;

  // NOTE: the buffer must read blank straight out of reset, so it is a reset flop array rather than a RAM.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < 32; i++) r_cells[i] <= BLANK_CHAR;
    end else if (i_wr_en) begin
      r_cells[i_wr_addr] <= i_wr_data;
    end
  end

  // NOTE: non-blocking throughout; the last assignment to a dirty bit in this block wins,
  // which is what gives host writes priority over the scan clearing that bit.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= SCAN;
      r_dirty <= '1;
      r_ptr   <= '0;
      r_timer <= '0;
      r_start <= 1'b0;
      r_addr  <= '0;
      r_char  <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        SCAN: begin
          if (!w_busy && r_dirty[r_ptr]) begin
            r_addr         <= ddram_addr(r_ptr);
            r_char         <= r_cells[r_ptr];
            r_dirty[r_ptr] <= 1'b0;
            r_start        <= 1'b1;
            r_state        <= ISSUE;
          end else begin
            r_ptr <= r_ptr + 5'd1;
          end
        end
        ISSUE: begin
          r_timer <= '0;
          r_state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (w_busy) begin
            r_state <= WAIT_DONE;
          end else if (r_timer == TIMER_LAST) begin
            // Driver never answered: leave ptr here so the same cell is retried first.
            r_dirty[r_ptr] <= 1'b1;
            r_state        <= SCAN;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!w_busy) begin
            r_ptr   <= r_ptr + 5'd1;
            r_state <= SCAN;
          end
        end
        default: r_state <= SCAN;
      endcase

      if (i_refresh) begin
        r_dirty <= '1;
      end else if (i_wr_en) begin
        r_dirty[i_wr_addr] <= 1'b1;
      end
    end
  end

  assign lcd.lcd_start = r_start;
  assign lcd.lcd_addr  = r_addr;
  assign lcd.lcd_char  = r_char;
  assign o_idle        = (r_state == SCAN) && (r_dirty == '0);

endmodule

// File: tb/tb_lcd_text_writer.sv
// Randomised bench for lcd_text_writer: a behavioural driver model plus a
// cell/dirty-set scoreboard judge every START the writer issues.
module tb_lcd_text_writer;

  localparam logic [7:0] BLANK  = 8'h20;
  localparam int         ACK_TO = 16;

  typedef enum {DRV_NORMAL, DRV_IGNORE, DRV_FORCE} drv_mode_t;

  logic       i_clk     = 1'b0;
  logic       i_rst     = 1'b1;
  logic       i_wr_en   = 1'b0;
  logic [4:0] i_wr_addr = '0;
  logic [7:0] i_wr_data = '0;
  logic       i_refresh = 1'b0;
  logic       o_idle;

  lcd_text_writer_if lcd ();

  lcd_text_writer #(.BLANK_CHAR(BLANK), .ACK_TIMEOUT(ACK_TO)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_refresh (i_refresh),
    .lcd       (lcd),
    .o_idle    (o_idle)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: what each cell holds, which cells still owe a transaction.
  logic [7:0] m_cell [32];
  bit         m_dirty [32];
  logic [7:0] m_sent [32];
  int         log_idx [$];
  logic [7:0] log_addr [$];
  logic [7:0] log_chr [$];

  bit         p_wr, p_ref;
  logic [4:0] p_addr;
  logic [7:0] p_data;

  drv_mode_t  drv_mode;
  int         drv_phase, drv_cnt;
  bit         prev_start;
  int         cycle;
  int         n_checks, n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_cell[i]  = BLANK;
      m_dirty[i] = 1'b1;
      m_sent[i]  = 8'h00;
    end
    p_wr = 1'b0; p_ref = 1'b0; p_addr = '0; p_data = '0;
    prev_start = 1'b0;
  endtask

  task automatic clear_log();
    log_idx.delete(); log_addr.delete(); log_chr.delete();
  endtask

  // One clock: observe the edge just taken, update model and driver, drive next inputs.
  task automatic step(input bit wr, input logic [4:0] a, input logic [7:0] d, input bit rf);
    int  idx;
    bit  ok;
    bit  seen;
    @(negedge i_clk);
    cycle++;
    seen = (lcd.lcd_start === 1'b1);
    if (seen) begin
      check("start_single_cycle", prev_start, 0);
      ok = 1'b1;
      if (lcd.lcd_addr <= 8'h0F) idx = int'(lcd.lcd_addr);
      else if (lcd.lcd_addr >= 8'h40 && lcd.lcd_addr <= 8'h4F) idx = 16 + int'(lcd.lcd_addr) - 'h40;
      else begin ok = 1'b0; idx = 0; end
      check("addr_in_map", ok, 1);
      if (ok) begin
        check("cell_was_dirty", m_dirty[idx], 1);
        check("char_matches_cell", lcd.lcd_char, m_cell[idx]);
        if (drv_mode != DRV_IGNORE) m_dirty[idx] = 1'b0;
        m_sent[idx] = lcd.lcd_char;
        log_idx.push_back(idx);
        log_addr.push_back(lcd.lcd_addr);
        log_chr.push_back(lcd.lcd_char);
      end
    end
    prev_start = seen;
    if (p_ref) for (int i = 0; i < 32; i++) m_dirty[i] = 1'b1;
    if (p_wr) begin
      m_cell[p_addr]  = p_data;
      m_dirty[p_addr] = 1'b1;
    end

    case (drv_mode)
      DRV_FORCE:  lcd.lcd_busy = 1'b1;
      DRV_IGNORE: lcd.lcd_busy = 1'b0;
      default: begin
        if (drv_phase == 0 && seen) begin
          drv_phase = 1;
          drv_cnt   = int'($urandom_range(0, 3));
        end
        if (drv_phase == 1) begin
          if (drv_cnt == 0) begin
            lcd.lcd_busy = 1'b1;
            drv_phase    = 2;
            drv_cnt      = int'($urandom_range(2, 5));
          end else begin
            drv_cnt--;
          end
        end else if (drv_phase == 2) begin
          drv_cnt--;
          if (drv_cnt == 0) begin
            lcd.lcd_busy = 1'b0;
            drv_phase    = 0;
          end
        end
      end
    endcase

    i_wr_en = wr; i_wr_addr = a; i_wr_data = d; i_refresh = rf;
    p_wr = wr; p_addr = a; p_data = d; p_ref = rf;
  endtask

  task automatic wait_start(input int bound, input string tag);
    int n0 = log_idx.size();
    int k  = 0;
    while (log_idx.size() == n0 && k < bound) begin
      step(0, '0, '0, 0);
      k++;
    end
    check(tag, log_idx.size() > n0, 1);
  endtask

  task automatic run_to_idle(input int bound, input string tag);
    int k    = 0;
    bit done = 1'b0;
    while (!done && k < bound) begin
      step(0, '0, '0, 0);
      k++;
      done = (o_idle === 1'b1) && (drv_phase == 0);
    end
    check(tag, done, 1);
  endtask

  // Full repaint: 32 blanks, each cell once, in ascending cyclic scan order.
  task automatic check_repaint(input string tag);
    check({tag, "_count"}, log_idx.size(), 32);
    for (int i = 0; i < log_idx.size() && i < 32; i++) begin
      check({tag, "_char"}, log_chr[i], BLANK);
      if (i > 0) check({tag, "_order"}, log_idx[i], (log_idx[i-1] + 1) % 32);
    end
  endtask

  function automatic int count_addr(input logic [7:0] addr);
    int n = 0;
    foreach (log_addr[i]) if (log_addr[i] == addr) n++;
    return n;
  endfunction

  function automatic logic [7:0] last_char_for(input logic [7:0] addr);
    logic [7:0] c = 8'hxx;
    foreach (log_addr[i]) if (log_addr[i] == addr) c = log_chr[i];
    return c;
  endfunction

  initial begin
    int t0;
    int k;
    n_checks = 0; n_errors = 0; cycle = 0;
    drv_phase = 0; drv_cnt = 0;
    drv_mode = DRV_FORCE;
    lcd.lcd_busy = 1'b1;
    model_reset();
    clear_log();

    // Reset state
    #1 i_rst = 1'b0;
    #1;
    check("rst_start", lcd.lcd_start, 0);
    check("rst_addr", lcd.lcd_addr, 8'h00);
    check("rst_char", lcd.lcd_char, 8'h00);
    check("rst_idle", o_idle, 0);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;

    // Driver busy with power-up init: nothing may be sent, then a full blank repaint.
    repeat (100) step(0, '0, '0, 0);
    check("no_start_while_busy", log_idx.size(), 0);
    drv_mode = DRV_NORMAL; lcd.lcd_busy = 1'b0; drv_phase = 0;
    run_to_idle(2000, "powerup_idle");
    check_repaint("powerup");

    // Single cell on line 2
    clear_log();
    step(1, 5'd17, 8'h41, 0);
    run_to_idle(500, "cell17_idle");
    check("cell17_count", log_addr.size(), 1);
    check("cell17_addr", last_char_for(8'h41) !== 8'hxx, 1);
    check("cell17_char", last_char_for(8'h41), 8'h41);

    // Two writes in one burst
    clear_log();
    step(1, 5'd3, 8'h48, 0);
    step(1, 5'd20, 8'h69, 0);
    run_to_idle(500, "burst_idle");
    check("burst_count", log_addr.size(), 2);
    check("burst_cell3_char", last_char_for(8'h03), 8'h48);
    check("burst_cell20_char", last_char_for(8'h44), 8'h69);

    // Driver ignores START: same cell retried after the timeout, nothing else in between.
    clear_log();
    drv_mode = DRV_IGNORE;
    step(1, 5'd9, 8'h39, 0);
    wait_start(100, "timeout_first_start");
    t0 = cycle;
    step(1, 5'd30, 8'h7E, 0);
    wait_start(60, "timeout_retry_start");
    check("timeout_log_len", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check("timeout_retry_addr", log_addr[1], 8'h09);
      check("timeout_retry_char", log_chr[1], 8'h39);
    end
    check("timeout_gap_in_range", (cycle - t0 >= ACK_TO + 1) && (cycle - t0 <= ACK_TO + 3), 1);
    drv_mode = DRV_NORMAL;
    run_to_idle(500, "timeout_idle");
    check("timeout_cell30_char", last_char_for(8'h4E), 8'h7E);

    // Rewrite of the in-flight cell during WAIT_DONE is sent again with the new char.
    clear_log();
    step(1, 5'd5, 8'h11, 0);
    wait_start(100, "rewrite_start");
    k = 0;
    while (lcd.lcd_busy !== 1'b1 && k < 10) begin step(0, '0, '0, 0); k++; end
    check("rewrite_busy_seen", lcd.lcd_busy, 1);
    step(0, '0, '0, 0);
    step(1, 5'd5, 8'h5A, 0);
    run_to_idle(500, "rewrite_idle");
    check("rewrite_cell5_count", count_addr(8'h05), 2);
    if (log_addr.size() >= 2) begin
      check("rewrite_first_char", log_chr[0], 8'h11);
      check("rewrite_second_char", log_chr[log_chr.size()-1], 8'h5A);
    end

    // Reset in the middle of a transaction, then a full blank repaint.
    clear_log();
    step(1, 5'd7, 8'h77, 0);
    wait_start(100, "midrst_start");
    k = 0;
    while (lcd.lcd_busy !== 1'b1 && k < 10) begin step(0, '0, '0, 0); k++; end
    step(0, '0, '0, 0);
    check("midrst_addr_before", lcd.lcd_addr, 8'h07);
    i_rst = 1'b0;
    #1;
    check("midrst_start", lcd.lcd_start, 0);
    check("midrst_addr", lcd.lcd_addr, 8'h00);
    check("midrst_char", lcd.lcd_char, 8'h00);
    check("midrst_idle", o_idle, 0);
    lcd.lcd_busy = 1'b0; drv_phase = 0;
    model_reset();
    repeat (2) step(0, '0, '0, 0);
    clear_log();
    i_rst = 1'b1;
    run_to_idle(2000, "midrst_idle");
    check_repaint("midrst");

    // Random writes and refreshes against the model.
    clear_log();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), 8'($urandom),
           $urandom_range(0, 96) == 0);
    end
    run_to_idle(3000, "random_idle");
    for (int i = 0; i < 32; i++) begin
      check("random_cell_flushed", m_dirty[i], 0);
      check("random_last_sent", m_sent[i], m_cell[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
